dma_line_writer: RTL and testbench



---
 rtl/dma_line_writer.sv | 123 ++++++++++++
 tb/tb_dma_line_writer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_line_writer.sv
// DMA initiator: fetches 64-bit lines from an I/O device and writes them to data memory
// one line per write, holding the data bus through a BR/BG handshake with the CPU.
module dma_line_writer #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_length,
  output logic                 cmd_ready,
  output logic                 bus_request,
  input  logic                 bus_grant,
  input  logic                 dev_valid,
  input  logic [LINE_SIZE-1:0] dev_data,
  output logic                 dev_ready,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  inout  wire  [LINE_SIZE-1:0] d_data,
  output logic                 dma_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] WR_LAST = 4'(MEM_LATENCY - 1);

  state_t               state, state_nx;
  logic [WORD_SIZE-1:0] addr_r;
  logic [WORD_SIZE:0]   lines_r;
  logic [LINE_SIZE-1:0] line_r;
  logic [3:0]           wr_cnt;
  logic                 rewrite;
  logic [WORD_SIZE:0]   len_lines;

  // Length is rounded up to whole lines in one extra bit so 0xFFFF words cannot overflow.
  assign len_lines = ({1'b0, cmd_length} + (WORD_SIZE+1)'(3)) >> 2;

  assign cmd_ready   = (state == IDLE);
  assign bus_request = (state == REQ) || (state == FETCH) || (state == WRITE) || (state == NEXT);
  assign dev_ready   = (state == FETCH) && bus_grant;
  assign d_writeM    = (state == WRITE);
  assign d_address   = addr_r;
  assign dma_done    = (state == DONE);
  assign d_data      = d_writeM ? line_r : {LINE_SIZE{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr_r  <= '0;
      lines_r <= '0;
      line_r  <= '0;
      wr_cnt  <= '0;
      rewrite <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          rewrite <= 1'b0;
          if (cmd_valid) begin
            addr_r  <= cmd_addr & ~WORD_SIZE'(3);
            lines_r <= len_lines;
          end
        end
        FETCH: begin
          if (dev_valid && dev_ready) line_r <= dev_data;
        end
        WRITE: begin
          // A lost grant restarts the hold count; the latched line is kept for the retry.
          if (!bus_grant) begin
            wr_cnt  <= '0;
            rewrite <= 1'b1;
          end else if (wr_cnt == WR_LAST) begin
            wr_cnt  <= '0;
            rewrite <= 1'b0;
          end else begin
            wr_cnt <= wr_cnt + 4'd1;
          end
        end
        NEXT: begin
          addr_r  <= addr_r + WORD_SIZE'(4);
          lines_r <= lines_r - (WORD_SIZE+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nx = (cmd_length == '0) ? DONE : REQ;
      end
      REQ: begin
        if (bus_grant) state_nx = rewrite ? WRITE : FETCH;
      end
      FETCH: begin
        if (dev_valid && bus_grant) state_nx = WRITE;
      end
      WRITE: begin
        if (!bus_grant)             state_nx = REQ;
        else if (wr_cnt == WR_LAST) state_nx = NEXT;
      end
      NEXT: begin
        state_nx = (lines_r == (WORD_SIZE+1)'(1)) ? DONE : FETCH;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_line_writer.sv
// Randomised scoreboard bench for dma_line_writer: stimulus queues expected line writes,
// a negedge monitor pops and compares them as the DUT writes memory.
module tb_dma_line_writer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_length = '0;
  logic        bus_grant = 1'b1;
  logic        dev_valid = 1'b0;
  logic [63:0] dev_data = '0;
  wire         cmd_ready, bus_request, dev_ready, d_writeM, dma_done;
  wire  [15:0] d_address;
  wire  [63:0] d_data;

  dma_line_writer #(.WORD_SIZE(16), .LINE_SIZE(64), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_length(cmd_length), .cmd_ready(cmd_ready),
    .bus_request(bus_request), .bus_grant(bus_grant),
    .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(dev_ready),
    .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data),
    .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] dev_q[$];
  logic [15:0] mem [65536];

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int accept_cnt = 0;
  int done_start = 0;
  int accept_start = 0;
  bit grant_random = 1'b0;
  bit grant_override = 1'b0;
  bit br_before_done = 1'b0;

  int run_len = 0;
  bit lost = 1'b0;
  bit prev_done = 1'b0;
  bit prev_br = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Monitor: every write cycle must match the oldest outstanding line; a line retires after
  // LAT consecutive cycles with grant held, and must drop the cycle after grant is lost.
  always @(negedge clk) begin
    if (!reset_n) begin
      run_len   = 0;
      lost      = 1'b0;
      prev_done = 1'b0;
      prev_br   = 1'b0;
    end else begin
      if (!bus_grant) checkOutput("dev_ready_gated", {63'd0, dev_ready}, 64'd0);
      if (lost) begin
        checkOutput("wr_drop_after_grant_loss", {63'd0, d_writeM}, 64'd0);
        lost    = 1'b0;
        run_len = 0;
      end else if (d_writeM) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", {63'd0, d_writeM}, 64'd0);
        end else begin
          checkOutput("wr_addr", {48'd0, d_address}, {48'd0, exp_q[0].addr});
          checkOutput("wr_data", d_data, exp_q[0].data);
          run_len++;
          if (!bus_grant) lost = 1'b1;
          else if (run_len == LAT) begin
            for (int k = 0; k < 4; k++) mem[16'(d_address + 16'(k))] = d_data[16*k +: 16];
            void'(exp_q.pop_front());
            run_len = 0;
          end
        end
      end else if (run_len != 0) begin
        checkOutput("write_hold_len", 64'(run_len), 64'(LAT));
        run_len = 0;
      end
      if (dma_done) begin
        checkOutput("done_pulse_width", {63'd0, prev_done}, 64'd0);
        checkOutput("br_low_at_done", {63'd0, bus_request}, 64'd0);
        br_before_done = prev_br;
        done_cnt++;
      end
      prev_done = dma_done;
      prev_br   = bus_request;
    end
  end

  // Device model: presents queued lines with random gaps, retires a line on handshake.
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = dev_valid && dev_ready && reset_n;
      @(posedge clk);
      #1;
      if (hs && dev_q.size() > 0) begin
        void'(dev_q.pop_front());
        accept_cnt++;
      end
      if (dev_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        dev_valid = 1'b1;
        dev_data  = dev_q[0];
      end else begin
        dev_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!grant_override) bus_grant = grant_random ? ($urandom_range(0, 4) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: a command becomes ceil(len/4) line writes at line-aligned, wrapping addresses.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] len, input bit seq_data);
    int          nlines;
    logic [15:0] base;
    logic [63:0] line;
    int          t = 0;
    nlines = (int'(len) + 3) / 4;
    base   = addr & 16'hFFFC;
    for (int i = 0; i < nlines; i++) begin
      if (seq_data) line = {16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)};
      else          line = {$urandom, $urandom};
      exp_q.push_back('{addr: 16'(base + 16'(4*i)), data: line});
      dev_q.push_back(line);
    end
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    done_start   = done_cnt;
    accept_start = accept_cnt;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_addr   = addr;
    cmd_length = len;
    @(negedge clk);
    checkOutput("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    exp_q.delete();
    dev_q.delete();
    dev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic waitDone(input string name, input int exp_lines);
    int t = 0;
    while (done_cnt == done_start && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    checkOutput({name, "_done_count"}, 64'(done_cnt - done_start), 64'd1);
    checkOutput({name, "_lines_fetched"}, 64'(accept_cnt - accept_start), 64'(exp_lines));
    checkOutput({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    checkOutput({name, "_br_before_done"}, {63'd0, br_before_done}, {63'd0, exp_lines != 0});
    if (done_cnt == done_start) doReset();
  endtask

  initial begin
    int t;
    int d0;
    logic [15:0] a;
    logic [15:0] l;

    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("rst_bus_request", {63'd0, bus_request}, 64'd0);
    checkOutput("rst_dev_ready", {63'd0, dev_ready}, 64'd0);
    checkOutput("rst_d_writeM", {63'd0, d_writeM}, 64'd0);
    checkOutput("rst_dma_done", {63'd0, dma_done}, 64'd0);
    checkOutput("rst_d_address", {48'd0, d_address}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("[TB] basic two-line transfer");
    applyStimulus(16'h0100, 16'd8, 1'b1);
    waitDone("basic", 2);
    for (int i = 0; i < 8; i++) checkOutput("mem_basic", {48'd0, mem[16'h0100 + i]}, 64'(i + 1));

    $display("[TB] unaligned address, partial line length");
    applyStimulus(16'h0043, 16'd5, 1'b0);
    waitDone("unaligned", 2);

    $display("[TB] zero length");
    applyStimulus(16'h1234, 16'd0, 1'b0);
    @(negedge clk);
    checkOutput("zero_len_done", {63'd0, dma_done}, 64'd1);
    checkOutput("zero_len_br", {63'd0, bus_request}, 64'd0);
    waitDone("zero_len", 0);

    $display("[TB] address wrap");
    applyStimulus(16'hFFFC, 16'd8, 1'b1);
    waitDone("wrap", 2);
    for (int i = 0; i < 4; i++) checkOutput("mem_wrap_hi", {48'd0, mem[16'hFFFC + i]}, 64'(i + 1));
    for (int i = 0; i < 4; i++) checkOutput("mem_wrap_lo", {48'd0, mem[i]}, 64'(i + 5));

    $display("[TB] grant loss during second write");
    applyStimulus(16'h0100, 16'd8, 1'b0);
    t = 0;
    while (!(d_writeM && d_address == 16'h0104) && t < 500) begin
      @(negedge clk);
      t++;
    end
    checkOutput("second_write_seen", {48'd0, d_address}, 64'h0104);
    @(posedge clk);
    #1;
    grant_override = 1'b1;
    bus_grant      = 1'b0;
    @(negedge clk);
    checkOutput("loss_br_held", {63'd0, bus_request}, 64'd1);
    @(negedge clk);
    checkOutput("loss_writeM_dropped", {63'd0, d_writeM}, 64'd0);
    checkOutput("loss_br_still", {63'd0, bus_request}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    bus_grant      = 1'b1;
    grant_override = 1'b0;
    waitDone("grant_loss", 2);

    $display("[TB] command while busy");
    applyStimulus(16'h2000, 16'd12, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_addr   = 16'h3000;
    cmd_length = 16'd4;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waitDone("busy_cmd", 3);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    checkOutput("busy_cmd_no_extra_done", 64'(done_cnt), 64'(d0));

    $display("[TB] random transfers with random grant");
    grant_random = 1'b1;
    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom);
      l = 16'($urandom_range(1, 24));
      applyStimulus(a, l, 1'b0);
      waitDone("random", (int'(l) + 3) / 4);
    end
    grant_random = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset during write");
    applyStimulus(16'h0500, 16'd16, 1'b0);
    t = 0;
    while (!d_writeM && t < 500) begin
      @(negedge clk);
      t++;
    end
    d0 = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_writeM", {63'd0, d_writeM}, 64'd0);
    checkOutput("async_rst_br", {63'd0, bus_request}, 64'd0);
    checkOutput("async_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("async_rst_done", {63'd0, dma_done}, 64'd0);
    doReset();
    repeat (30) @(negedge clk);
    checkOutput("post_rst_no_done", 64'(done_cnt), 64'(d0));
    checkOutput("post_rst_idle", {63'd0, cmd_ready}, 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
